// File: rtl/irq_source_ctrl.sv
// Interrupt source conditioner: debounces a push-button, buffers Ethernet words,
// and issues one interrupt at a time to the processor until irq_done retires it.
module irq_source_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned ETH_FIFO_DEPTH  = 4,
    parameter logic [31:0] KEY_CODE        = 32'h0000_0001
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              key_raw,
    input  logic                              eth_valid,
    input  logic [31:0]                       eth_data,
    output logic                              eth_ready,
    input  logic                              irq_done,
    output logic                              interrupt_key,
    output logic                              interrupt_eth,
    output logic [31:0]                       interrupt_source_data,
    output logic                              key_pending,
    output logic [$clog2(ETH_FIFO_DEPTH):0]   eth_count
);

    localparam int unsigned PW   = $clog2(ETH_FIFO_DEPTH);
    localparam int unsigned CW   = PW + 1;
    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_e;
    typedef enum logic       {SEL_KEY, SEL_ETH}       sel_e;

    state_e state_q;
    sel_e   sel_q;

    logic [1:0]      sync_q;
    logic            key_sync;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            filt_q, filt_d, filt_prev_q;
    logic            key_rise;
    logic            key_pending_q, key_pending_d;

    logic [31:0]   mem_q [ETH_FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] eth_count_q, eth_count_d;
    logic          push, pop, key_clear;

    logic        int_key_q, int_eth_q;
    logic [31:0] src_data_q;

    // NOTE: sequential state always uses non-blocking assignments so every flop
    // samples the pre-edge value of its sources, independent of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q      <= 2'b00;
            db_cnt_q    <= '0;
            filt_q      <= 1'b0;
            filt_prev_q <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], key_raw};
            db_cnt_q    <= db_cnt_d;
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
        end
    end

    assign key_sync = sync_q[1];

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        db_cnt_d = '0;
        filt_d   = filt_q;
        if (key_sync != filt_q) begin
            if (db_cnt_q == DB_LAST) begin
                filt_d = key_sync;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    assign key_rise  = filt_q & ~filt_prev_q;
    assign key_clear = (state_q == ISSUE) && (sel_q == SEL_KEY);

    // A press detected in the clearing cycle must survive the clear.
    always_comb begin
        key_pending_d = key_pending_q;
        if (key_rise) begin
            key_pending_d = 1'b1;
        end else if (key_clear) begin
            key_pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_pending_q <= 1'b0;
        end else begin
            key_pending_q <= key_pending_d;
        end
    end

    assign eth_ready = (eth_count_q != CW'(ETH_FIFO_DEPTH));
    assign push      = eth_valid && eth_ready;
    assign pop       = (state_q == ISSUE) && (sel_q == SEL_ETH);

    always_comb begin
        eth_count_d = eth_count_q;
        case ({push, pop})
            2'b10:   eth_count_d = eth_count_q + 1'b1;
            2'b01:   eth_count_d = eth_count_q - 1'b1;
            default: eth_count_d = eth_count_q;
        endcase
    end

    // NOTE: the storage array has no reset; pointers and count define validity,
    // so stale words are never observable.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= eth_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            eth_count_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            eth_count_q <= eth_count_d;
        end
    end

    // Pulse and payload are loaded on entry to ISSUE so both are visible during it;
    // the matching clear/pop lands at the end of ISSUE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            sel_q      <= SEL_KEY;
            int_key_q  <= 1'b0;
            int_eth_q  <= 1'b0;
            src_data_q <= '0;
        end else begin
            int_key_q <= 1'b0;
            int_eth_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (key_pending_q) begin
                        state_q    <= ISSUE;
                        sel_q      <= SEL_KEY;
                        int_key_q  <= 1'b1;
                        src_data_q <= KEY_CODE;
                    end else if (eth_count_q != '0) begin
                        state_q    <= ISSUE;
                        sel_q      <= SEL_ETH;
                        int_eth_q  <= 1'b1;
                        src_data_q <= mem_q[rd_ptr_q];
                    end
                end
                ISSUE:     state_q <= WAIT_DONE;
                WAIT_DONE: if (irq_done) state_q <= IDLE;
                default:   state_q <= IDLE;
            endcase
        end
    end

    assign interrupt_key         = int_key_q;
    assign interrupt_eth         = int_eth_q;
    assign interrupt_source_data = src_data_q;
    assign key_pending           = key_pending_q;
    assign eth_count             = eth_count_q;

endmodule

// File: tb/tb_irq_source_ctrl.sv
// Directed bench for irq_source_ctrl: vector table for Ethernet ordering plus
// hand-written sequences for debounce, full FIFO, priority and mid-service reset.
module tb_irq_source_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_raw;
    logic        eth_valid;
    logic [31:0] eth_data;
    logic        eth_ready;
    logic        irq_done;
    logic        interrupt_key;
    logic        interrupt_eth;
    logic [31:0] interrupt_source_data;
    logic        key_pending;
    logic [2:0]  eth_count;

    int total = 0;
    int bad   = 0;
    int overlaps = 0;
    int max_cnt  = 0;
    logic [32:0] log_q[$];

    irq_source_ctrl #(
        .DEBOUNCE_CYCLES(16),
        .ETH_FIFO_DEPTH (4),
        .KEY_CODE       (32'h0000_0001)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .key_raw              (key_raw),
        .eth_valid            (eth_valid),
        .eth_data             (eth_data),
        .eth_ready            (eth_ready),
        .irq_done             (irq_done),
        .interrupt_key        (interrupt_key),
        .interrupt_eth        (interrupt_eth),
        .interrupt_source_data(interrupt_source_data),
        .key_pending          (key_pending),
        .eth_count            (eth_count)
    );

    always #5 clk = ~clk;

    // Event log of every issued interrupt: {is_key, payload}.
    always @(posedge clk) begin
        #2;
        if (!rst) begin
            if (interrupt_key || interrupt_eth)
                log_q.push_back({interrupt_key, interrupt_source_data});
            if (interrupt_key && interrupt_eth) overlaps++;
            if (int'(eth_count) > max_cnt) max_cnt = int'(eth_count);
        end
    end

    typedef struct {
        logic        valid;
        logic [31:0] data;
        logic        done;
        logic        exp_ie;
        logic [31:0] exp_data;
        logic [2:0]  exp_cnt;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    function automatic logic [32:0] log_at(input int i);
        if (i < log_q.size()) return log_q[i];
        return '1;
    endfunction

    // Retire interrupts by strobing irq_done every fourth cycle.
    task automatic serve(input int n);
        for (int i = 0; i < n; i++) begin
            irq_done = 1'b1;
            step();
            irq_done = 1'b0;
            steps(3);
        end
    endtask

    task automatic push_burst(input logic [31:0] w[$]);
        for (int i = 0; i < w.size(); i++) begin
            eth_valid = 1'b1;
            eth_data  = w[i];
            step();
        end
        eth_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] words[$];
        logic [32:0] exp_log[$];
        logic        pushed;

        vecs[0]  = '{1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0000_0001, 3'd1};
        vecs[1]  = '{1'b1, 32'h12345678, 1'b0, 1'b1, 32'hDEADBEEF,  3'd2};
        vecs[2]  = '{1'b1, 32'hCAFEF00D, 1'b0, 1'b0, 32'hDEADBEEF,  3'd2};
        vecs[3]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'hDEADBEEF,  3'd2};
        vecs[4]  = '{1'b0, 32'h0,        1'b1, 1'b0, 32'hDEADBEEF,  3'd2};
        vecs[5]  = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h12345678,  3'd2};
        vecs[6]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h12345678,  3'd1};
        vecs[7]  = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h12345678,  3'd1};
        vecs[8]  = '{1'b0, 32'h0,        1'b0, 1'b1, 32'hCAFEF00D,  3'd1};
        vecs[9]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'hCAFEF00D,  3'd0};
        vecs[10] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'hCAFEF00D,  3'd0};
        vecs[11] = '{1'b0, 32'h0,        1'b0, 1'b0, 32'hCAFEF00D,  3'd0};

        // Reset held with active inputs.
        rst = 1'b1; key_raw = 1'b1; eth_valid = 1'b1; eth_data = 32'hFFFF_FFFF; irq_done = 1'b0;
        steps(3);
        check("rst_int_key",  interrupt_key, 0);
        check("rst_int_eth",  interrupt_eth, 0);
        check("rst_data",     interrupt_source_data, 0);
        check("rst_key_pend", key_pending, 0);
        check("rst_count",    eth_count, 0);
        check("rst_ready",    eth_ready, 1);

        // Release with key still held: no pulse before the debounce time.
        eth_valid = 1'b0;
        rst = 1'b0;
        log_q.delete();
        steps(10);
        check("no_early_key", log_q.size(), 0);
        check("empty_after_rst", eth_count, 0);
        steps(30);
        check("held_key_pulses", log_q.size(), 1);
        check("held_key_payload", log_at(0), {1'b1, 32'h1});
        irq_done = 1'b1; step(); irq_done = 1'b0;
        key_raw = 1'b0;
        steps(30);
        check("release_no_pulse", log_q.size(), 1);

        // Debounce: 10-cycle glitch rejected, 40-cycle press gives one pulse.
        log_q.delete();
        key_raw = 1'b1; steps(10); key_raw = 1'b0;
        steps(30);
        check("glitch_rejected", log_q.size(), 0);
        key_raw = 1'b1; steps(40);
        check("press_one_pulse", log_q.size(), 1);
        check("press_payload", log_at(0), {1'b1, 32'h1});
        steps(5);
        check("press_data_held", interrupt_source_data, 32'h1);
        check("press_no_repeat", log_q.size(), 1);
        irq_done = 1'b1; step(); irq_done = 1'b0;
        key_raw = 1'b0;
        steps(30);

        // Ethernet ordering, cycle-accurate table.
        for (int i = 0; i < 12; i++) begin
            eth_valid = vecs[i].valid;
            eth_data  = vecs[i].data;
            irq_done  = vecs[i].done;
            step();
            check($sformatf("vec%0d_int_eth", i), interrupt_eth, vecs[i].exp_ie);
            check($sformatf("vec%0d_int_key", i), interrupt_key, 0);
            check($sformatf("vec%0d_data", i),    interrupt_source_data, vecs[i].exp_data);
            check($sformatf("vec%0d_count", i),   eth_count, vecs[i].exp_cnt);
            check($sformatf("vec%0d_ready", i),   eth_ready, 1);
        end
        eth_valid = 1'b0; irq_done = 1'b0;

        // Full FIFO: first word issues, four stored, sixth stalls until a pop.
        log_q.delete();
        max_cnt = 0;
        words = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4};
        push_burst(words);
        check("full_count", eth_count, 4);
        check("full_ready", eth_ready, 0);
        check("full_data_w0", interrupt_source_data, 32'hA0);
        eth_valid = 1'b1; eth_data = 32'hA5;
        steps(3);
        check("stall_count", eth_count, 4);
        check("stall_ready", eth_ready, 0);
        irq_done = 1'b1; step(); irq_done = 1'b0;
        pushed = 1'b0;
        for (int k = 0; k < 20 && !pushed; k++) begin
            if (eth_ready) pushed = 1'b1;
            step();
        end
        eth_valid = 1'b0;
        check("sixth_accepted", pushed, 1);
        serve(8);
        check("full_events", log_q.size(), 6);
        for (int i = 0; i < 6; i++)
            check($sformatf("full_order%0d", i), log_at(i), {1'b0, 32'hA0 + 32'(i)});
        check("full_max_count", max_cnt, 4);
        check("full_drained", eth_count, 0);

        // Priority: key pressed while two eth words wait behind a WAIT_DONE.
        log_q.delete();
        words = '{32'hB0, 32'hB1, 32'hB2};
        push_burst(words);
        check("prio_queued", eth_count, 2);
        key_raw = 1'b1; steps(30); key_raw = 1'b0; steps(30);
        check("prio_key_pending", key_pending, 1);
        check("prio_blocked", log_q.size(), 1);
        irq_done = 1'b1; step(); irq_done = 1'b0;
        step();
        check("prio_key_first", interrupt_key, 1);
        check("prio_eth_quiet", interrupt_eth, 0);
        check("prio_key_data", interrupt_source_data, 32'h1);
        step();
        check("prio_pending_clr", key_pending, 0);
        key_raw = 1'b1; steps(30); key_raw = 1'b0; steps(30);
        check("prio_second_press", key_pending, 1);
        serve(8);
        exp_log = '{{1'b0, 32'hB0}, {1'b1, 32'h1}, {1'b1, 32'h1}, {1'b0, 32'hB1}, {1'b0, 32'hB2}};
        check("prio_events", log_q.size(), exp_log.size());
        for (int i = 0; i < exp_log.size(); i++)
            check($sformatf("prio_order%0d", i), log_at(i), exp_log[i]);
        check("prio_drained", eth_count, 0);

        // Reset in WAIT_DONE with three words queued.
        words = '{32'hC0, 32'hC1, 32'hC2, 32'hC3};
        push_burst(words);
        check("mid_queued", eth_count, 3);
        rst = 1'b1;
        #1;
        check("mid_rst_count", eth_count, 0);
        check("mid_rst_data",  interrupt_source_data, 0);
        check("mid_rst_ready", eth_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        log_q.delete();
        irq_done = 1'b1; step(); irq_done = 1'b0;
        steps(10);
        check("mid_no_pulse", log_q.size(), 0);
        check("mid_count", eth_count, 0);

        check("never_both", overlaps, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
